// File: rtl/rv_bus_arb.sv
// rv_bus_arb: arbitrates an instruction-fetch port and a load/store port onto
// a single memory bus, one transaction outstanding at a time.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req, if_addr          fetch request and word address (held until if_ack)
//   if_ack, if_rdata         one-cycle fetch completion pulse and data
//   ls_req, ls_we, ls_addr,
//   ls_wdata, ls_be          load/store request and payload (held until ls_ack)
//   ls_ack, ls_rdata         one-cycle load/store completion pulse and data
//   err                      timeout flag, valid with if_ack/ls_ack
//   bus_req, bus_we, bus_addr,
//   bus_wdata, bus_be        transaction toward memory, payload registered
//   bus_ack, bus_rdata       memory completion and read data
module rv_bus_arb #(
    parameter int TIMEOUT    = 16,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_be,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] TO = 8'(TIMEOUT);
    localparam logic [3:0] SL = 4'(STARVE_LIM);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

    state_t      state, nxt;
    logic        owner_if;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [7:0]  wait_cnt;
    logic [3:0]  starve_cnt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                // Load/store wins a tie unless fetch has been passed over STARVE_LIM times.
                if (ls_req && (!if_req || starve_cnt != SL))
                    nxt = DATA;
                else if (if_req)
                    nxt = FETCH;
            end
            FETCH, DATA: nxt = (bus_ack || wait_cnt == TO) ? RESP : state;
            RESP:        nxt = IDLE;
            default:     nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner_if   <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: begin
                    if (nxt == DATA) begin
                        owner_if  <= 1'b0;
                        bus_we    <= ls_we;
                        bus_addr  <= ls_addr;
                        bus_wdata <= ls_wdata;
                        bus_be    <= ls_be;
                        wait_cnt  <= 8'd1;
                        if (if_req)
                            starve_cnt <= (starve_cnt == SL) ? SL : starve_cnt + 4'd1;
                    end else if (nxt == FETCH) begin
                        owner_if   <= 1'b1;
                        bus_we     <= 1'b0;
                        bus_addr   <= if_addr;
                        bus_wdata  <= '0;
                        bus_be     <= 4'hF;
                        wait_cnt   <= 8'd1;
                        starve_cnt <= '0;
                    end
                end
                FETCH, DATA: begin
                    // An ack in the timeout cycle still counts as a good completion.
                    if (bus_ack) begin
                        rdata_q <= bus_we ? 32'd0 : bus_rdata;
                        err_q   <= 1'b0;
                    end else if (wait_cnt == TO) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: wait_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        bus_req  = (state == FETCH) || (state == DATA);
        if_ack   = (state == RESP) && owner_if;
        ls_ack   = (state == RESP) && !owner_if;
        if_rdata = if_ack ? rdata_q : '0;
        ls_rdata = ls_ack ? rdata_q : '0;
        err      = (state == RESP) && err_q;
    end

endmodule

// File: tb/tb_rv_bus_arb.sv
// tb_rv_bus_arb: directed self-checking bench for rv_bus_arb.
module tb_rv_bus_arb;

    logic        clk, rst;
    logic        if_req, if_ack, ls_req, ls_we, ls_ack, err;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  ls_be, bus_be;

    int total = 0;
    int bad   = 0;

    rv_bus_arb #(.TIMEOUT(16), .STARVE_LIM(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_be(ls_be), .ls_ack(ls_ack), .ls_rdata(ls_rdata), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sel_ls;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        int          dly;
        logic [31:0] rd;
        logic        e_we;
        logic [31:0] e_wd;
        logic [3:0]  e_be;
        int          e_n;
        logic        e_err;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " bus_req"}, 32'(bus_req), 0);
        chk({tag, " if_ack"}, 32'(if_ack), 0);
        chk({tag, " ls_ack"}, 32'(ls_ack), 0);
        chk({tag, " err"}, 32'(err), 0);
        chk({tag, " if_rdata"}, if_rdata, 0);
        chk({tag, " ls_rdata"}, ls_rdata, 0);
    endtask

    task automatic run(input int idx, input vec_t v);
        int n;
        string t;
        t = $sformatf("vec%0d", idx);
        @(negedge clk);
        if_req = !v.sel_ls; ls_req = v.sel_ls;
        if_addr = v.addr; ls_addr = v.addr; ls_we = v.we; ls_wdata = v.wd; ls_be = v.be;
        bus_rdata = v.rd; bus_ack = 0;
        @(negedge clk);
        chk({t, " bus_req"}, 32'(bus_req), 1);
        chk({t, " bus_addr"}, bus_addr, v.addr);
        chk({t, " bus_we"}, 32'(bus_we), 32'(v.e_we));
        chk({t, " bus_wdata"}, bus_wdata, v.e_wd);
        chk({t, " bus_be"}, 32'(bus_be), 32'(v.e_be));
        n = 0;
        while (bus_req && n < 40) begin
            n++;
            bus_ack = (n == v.dly);
            @(negedge clk);
        end
        bus_ack = 0; if_req = 0; ls_req = 0;
        chk({t, " bus_cycles"}, 32'(n), 32'(v.e_n));
        chk({t, " if_ack"}, 32'(if_ack), 32'(!v.sel_ls));
        chk({t, " ls_ack"}, 32'(ls_ack), 32'(v.sel_ls));
        chk({t, " err"}, 32'(err), 32'(v.e_err));
        chk({t, " rdata"}, v.sel_ls ? ls_rdata : if_rdata, v.e_rd);
        chk({t, " other_rdata"}, v.sel_ls ? if_rdata : ls_rdata, 0);
        @(negedge clk);
        chk_idle_outputs({t, " after"});
    endtask

    initial begin
        int cnt, cyc;
        logic [31:0] exp_addr;
        vecs[0] = '{0, 1, 32'h100, 32'hFFFF, 4'h2, 1, 32'hDEADBEEF, 0, 32'h0, 4'hF, 1, 0, 32'hDEADBEEF};
        vecs[1] = '{1, 0, 32'h40, 32'h0, 4'hF, 3, 32'hCAFEF00D, 0, 32'h0, 4'hF, 3, 0, 32'hCAFEF00D};
        vecs[2] = '{1, 1, 32'h2000, 32'h12345678, 4'h3, 2, 32'hFFFFFFFF, 1, 32'h12345678, 4'h3, 2, 0, 32'h0};
        vecs[3] = '{1, 0, 32'h80, 32'h0, 4'hF, 0, 32'h55555555, 0, 32'h0, 4'hF, 16, 1, 32'h0};
        vecs[4] = '{1, 0, 32'h84, 32'h0, 4'h1, 16, 32'hA5A5A5A5, 0, 32'h0, 4'h1, 16, 0, 32'hA5A5A5A5};
        vecs[5] = '{0, 0, 32'h200, 32'h0, 4'h0, 0, 32'h66666666, 0, 32'h0, 4'hF, 16, 1, 32'h0};
        vecs[6] = '{1, 0, 32'h88, 32'h0, 4'hC, 1, 32'h0BADF00D, 0, 32'h0, 4'hC, 1, 0, 32'h0BADF00D};

        rst = 1; if_req = 0; ls_req = 0; ls_we = 0; if_addr = 0; ls_addr = 0;
        ls_wdata = 0; ls_be = 0; bus_ack = 0; bus_rdata = 0;
        @(negedge clk); @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset bus_addr", bus_addr, 0);
        chk("reset bus_wdata", bus_wdata, 0);
        chk("reset bus_be", 32'(bus_be), 0);
        chk("reset bus_we", 32'(bus_we), 0);
        rst = 0;

        for (int i = 0; i < 7; i++) run(i, vecs[i]);

        // Simultaneous requests: store goes first, then fetch.
        @(negedge clk);
        if_req = 1; if_addr = 32'h1000; bus_rdata = 32'h13572468;
        ls_req = 1; ls_we = 1; ls_addr = 32'h2000; ls_wdata = 32'h12345678; ls_be = 4'h3;
        @(negedge clk);
        chk("both bus_req", 32'(bus_req), 1);
        chk("both first_addr", bus_addr, 32'h2000);
        chk("both first_we", 32'(bus_we), 1);
        chk("both first_wdata", bus_wdata, 32'h12345678);
        chk("both first_be", 32'(bus_be), 32'h3);
        bus_ack = 1;
        @(negedge clk);
        bus_ack = 0;
        chk("both ls_ack", 32'(ls_ack), 1);
        chk("both if_ack_early", 32'(if_ack), 0);
        ls_req = 0;
        @(negedge clk);
        chk("both idle_gap", 32'(bus_req), 0);
        @(negedge clk);
        chk("both second_addr", bus_addr, 32'h1000);
        chk("both second_we", 32'(bus_we), 0);
        bus_ack = 1;
        @(negedge clk);
        bus_ack = 0;
        chk("both if_ack", 32'(if_ack), 1);
        chk("both if_rdata", if_rdata, 32'h13572468);
        if_req = 0;

        // Continuous contention: four loads, then one fetch, repeating.
        @(negedge clk);
        if_addr = 32'h300; ls_addr = 32'h400; ls_we = 0; if_req = 1; ls_req = 1;
        cnt = 0; cyc = 0;
        while (cnt < 10 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            bus_ack = bus_req;
            if (bus_req) begin
                exp_addr = (cnt % 5 == 4) ? 32'h300 : 32'h400;
                chk($sformatf("starve grant%0d", cnt), bus_addr, exp_addr);
                cnt++;
            end
        end
        chk("starve grant_count", 32'(cnt), 10);
        @(negedge clk);
        if_req = 0; ls_req = 0; bus_ack = 0;
        @(negedge clk);
        chk_idle_outputs("starve end");

        // Requester withdraws mid-transaction; completion still acks.
        @(negedge clk);
        ls_req = 1; ls_we = 0; ls_addr = 32'h500; bus_rdata = 32'h11112222;
        @(negedge clk);
        chk("drop bus_req", 32'(bus_req), 1);
        ls_req = 0;
        @(negedge clk);
        chk("drop still_busy", 32'(bus_req), 1);
        bus_ack = 1;
        @(negedge clk);
        bus_ack = 0;
        chk("drop ls_ack", 32'(ls_ack), 1);
        chk("drop ls_rdata", ls_rdata, 32'h11112222);
        @(negedge clk);

        // Asynchronous reset in the middle of a fetch.
        if_req = 1; if_addr = 32'h600; bus_rdata = 32'h0;
        @(negedge clk);
        chk("rst busy", 32'(bus_req), 1);
        #2 rst = 1;
        #1;
        chk_idle_outputs("rst async");
        chk("rst bus_addr", bus_addr, 0);
        chk("rst bus_be", 32'(bus_be), 0);
        if_req = 0;
        @(negedge clk);
        chk_idle_outputs("rst held");
        rst = 0;
        if_req = 1; if_addr = 32'h700; bus_rdata = 32'h77;
        @(negedge clk);
        chk("post_rst bus_req", 32'(bus_req), 1);
        chk("post_rst bus_addr", bus_addr, 32'h700);
        bus_ack = 1;
        @(negedge clk);
        bus_ack = 0;
        chk("post_rst if_ack", 32'(if_ack), 1);
        chk("post_rst if_rdata", if_rdata, 32'h77);
        chk("post_rst err", 32'(err), 0);
        if_req = 0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_bus_arb.md
RV_BUS_ARB -- requirements
Module: rv_bus_arb

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; all flops SHALL clear immediately on rst assertion.
REQ-002 Parameter TIMEOUT, 16, max cycles to wait for bus_ack before aborting a transaction (range 1..255).
REQ-003 Parameter STARVE_LIM, 4, max consecutive LS grants while if_req is pending before fetch is forced (range 1..15).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous reset, active high.
REQ-006 if_req  in  1  fetch request; held with if_addr stable until if_ack.
REQ-007 if_addr  in  32  fetch word address.
REQ-008 if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 if_rdata  out  32  fetch data; valid while if_ack=1.
REQ-010 ls_req  in  1  load/store request; held with payload stable until ls_ack.
REQ-011 ls_we  in  1  1=store, 0=load.
REQ-012 ls_addr  in  32  load/store address.
REQ-013 ls_wdata  in  32  store data.
REQ-014 ls_be  in  4  byte enables.
REQ-015 ls_ack  out  1  one-cycle load/store completion pulse.
REQ-016 ls_rdata  out  32  load data; valid while ls_ack=1.
REQ-017 err  out  1  timeout flag; valid with if_ack/ls_ack.
REQ-018 bus_req  out  1  transaction active toward memory.
REQ-019 bus_we, bus_addr[32], bus_wdata[32], bus_be[4]  out  registered transaction payload.
REQ-020 bus_ack  in  1  memory completion, sampled only while bus_req=1.
REQ-021 bus_rdata  in  32  memory read data, valid with bus_ack.

Function
REQ-022 FSM states SHALL be IDLE, FETCH, DATA, RESP; one transaction outstanding at a time.
REQ-023 IDLE: ls_req only -> DATA; if_req only -> FETCH; both -> DATA unless starve_cnt==STARVE_LIM, then FETCH; none -> stay.
REQ-024 On leaving IDLE the selected payload SHALL be latched into bus_* registers (fetch: bus_we=0, bus_be=4'hF, bus_wdata=0).
REQ-025 bus_req SHALL be 1 exactly in FETCH and DATA; payload SHALL stay constant in those states.
REQ-026 In FETCH/DATA, bus_ack=1 -> RESP, capturing bus_rdata (stores capture 0) and err=0.
REQ-027 In FETCH/DATA, wait_cnt counts cycles from 1; bus_ack=0 with wait_cnt==TIMEOUT -> RESP with err=1, rdata=0; a bus_ack in that same cycle SHALL take precedence (err=0).
REQ-028 RESP SHALL last one cycle, pulse if_ack or ls_ack per owner with captured rdata and err, then -> IDLE.
REQ-029 Minimum latency: req sampled in IDLE at cycle N, bus_req at N+1, bus_ack at N+1 gives ack at N+2, next grant sampled at N+3.
REQ-030 starve_cnt SHALL increment (saturating at STARVE_LIM) on each DATA grant made while if_req=1, and clear on each FETCH grant.
REQ-031 if_rdata/ls_rdata/err SHALL be 0 whenever the corresponding ack is 0.
REQ-032 A requester dropping req before ack SHALL not affect an in-flight transaction; completion still pulses ack.

Reset
REQ-033 Reset SHALL force state=IDLE, bus_req=0, all bus_* payload=0, if_ack=ls_ack=0, rdatas=0, err=0, wait_cnt=0, starve_cnt=0.
REQ-034 Reset asserted mid-transaction SHALL drop bus_req in the same cycle without issuing an ack; first grant after release follows REQ-023.

Verification
REQ-035 if_req, if_addr=0x100, bus_ack one cycle after bus_req, bus_rdata=0xDEADBEEF -> bus_addr=0x100, bus_we=0, bus_be=F; if_ack=1, if_rdata=0xDEADBEEF at req+2.
REQ-036 if_req and ls_req (store, addr 0x2000, wdata 0x12345678, be 0x3) same cycle -> store issued first with exact payload, ls_ack, then fetch issued.
REQ-037 ls_req and if_req held continuously, bus_ack immediate -> exactly STARVE_LIM=4 LS transactions, then one fetch, pattern repeating.
REQ-038 Load, bus_ack never asserted -> bus_req high 16 cycles, then ls_ack=1, err=1, ls_rdata=0; next request serviced normally.
REQ-039 Load with bus_ack arriving on cycle 16 -> err=0, ls_rdata = bus_rdata.
REQ-040 rst pulsed while bus_req=1 -> bus_req=0 immediately, no ack, all outputs 0; new if_req after release completes normally.
